panel_scanner: RTL and testbench

PANEL_SCANNER -- requirements
Module: panel_scanner

---
 rtl/panel_scanner.sv | 247 ++++++++++++++++++++++++
 tb/tb_panel_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_scanner.sv
// -----------------------------------------------------------------------------
// panel_scanner
//
// Front-panel scanner for a lamp chain (74HC595) and a switch chain (74HC165).
// Frames run back to back: LOAD -> SHIFT -> LATCH -> LOAD, each frame exactly
// 68*CLK_DIV clk cycles long.
//
//   LOAD  : 2*CLK_DIV clks, load_n=0 (switch chain parallel load), sclk=0.
//           The lamp word {ema, addr, data, run, 4'b0} is snapshotted on the
//           first clk, so later lamp changes only affect the next frame.
//   SHIFT : 32 sclk periods (CLK_DIV clks low, CLK_DIV clks high). sdo
//           carries the inverted lamp bit, MSB first; sdi is sampled on the
//           clk where sclk rises.
//   LATCH : 2*CLK_DIV clks with latch=1. On the last clk frame_done pulses
//           and sr/dsel/ctl take the inverted received switch bits.
//
// Parameters
//   CLK_DIV    clk cycles per sclk half-period (2..255)
//   CHAIN_BITS bits per frame (32 only)
//
// Ports
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset; aborts the frame in progress
//   ema[2:0]   extended-address lamps
//   addr[11:0] address lamps
//   data[11:0] data/state lamps
//   run        RUN lamp
//   sclk       shared serial clock for both chains
//   sdo        lamp serial data (active-low lamps at the pin)
//   latch      lamp chain storage-register clock
//   load_n     switch chain parallel load, active-low
//   sdi        switch serial data (active-low switches at the pin)
//   sr[11:0]   switch register, true polarity
//   dsel[5:0]  display-select switches
//   ctl[8:0]   {dep, sw, single_step, halt, exam, cont, extd_addr,
//               addr_load, clear}
//   frame_done one-clk pulse at the end of every completed frame
//
// Build option
//   PANEL_DEBOUNCE_EN : when defined, sr/dsel/ctl only update when the 27
//   received switch bits match those of the previous frame. The first frame
//   after reset only fills the history register.
// -----------------------------------------------------------------------------
module panel_scanner #(
  parameter int CLK_DIV    = 4,
  parameter int CHAIN_BITS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  ema,
  input  logic [11:0] addr,
  input  logic [11:0] data,
  input  logic        run,
  output logic        sclk,
  output logic        sdo,
  output logic        latch,
  output logic        load_n,
  input  logic        sdi,
  output logic [11:0] sr,
  output logic [5:0]  dsel,
  output logic [8:0]  ctl,
  output logic        frame_done
);

  localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] PHASE_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST   = 5'(CHAIN_BITS - 1);
  localparam int         SW_BITS    = 27;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                state;
  logic [8:0]            div_cnt;
  logic [4:0]            bit_cnt;

  // Lamp snapshot being shifted out, MSB in the top bit.
  logic [CHAIN_BITS-1:0] tx_p0;
  // Switch samples; sample k ends up in bit k after a full frame.
  logic [CHAIN_BITS-1:0] rx_p1;

  logic                  snap_stb;
  logic                  shift_stb;
  logic                  sample_stb;

`ifdef PANEL_DEBOUNCE_EN
  logic [SW_BITS-1:0]    hist_p2;
  logic                  primed;
  logic                  hist_stb;
`endif

  // Lamp word in shift order; bit 31 goes out first.
  function automatic logic [31:0] lamp_word(input logic [2:0]  e,
                                            input logic [11:0] a,
                                            input logic [11:0] d,
                                            input logic        r);
    return {e, a, d, r, 4'b0000};
  endfunction

  // Pins are active-low; received bits are inverted into true polarity.
  function automatic logic [11:0] sr_decode(input logic [SW_BITS-1:0] raw);
    return ~raw[11:0];
  endfunction

  function automatic logic [5:0] dsel_decode(input logic [SW_BITS-1:0] raw);
    return ~raw[17:12];
  endfunction

  function automatic logic [8:0] ctl_decode(input logic [SW_BITS-1:0] raw);
    return ~raw[26:18];
  endfunction

  // Data-path strobes derived from the control state. The last sclk fall
  // does not advance the lamp shifter: there is no 33rd bit.
  assign snap_stb   = resetn && (state == ST_LOAD) && (div_cnt == '0);
  assign shift_stb  = resetn &&
                      (((state == ST_LOAD) && (div_cnt == PHASE_LAST)) ||
                       ((state == ST_SHIFT) && (div_cnt == HALF_LAST) &&
                        sclk && (bit_cnt != BIT_LAST)));
  assign sample_stb = resetn && (state == ST_SHIFT) &&
                      (div_cnt == HALF_LAST) && !sclk;
`ifdef PANEL_DEBOUNCE_EN
  assign hist_stb   = resetn && (state == ST_LATCH) &&
                      (div_cnt == PHASE_LAST);
`endif

  // ---- p0: lamp snapshot / serializer ----
  always_ff @(posedge clk) begin
    if (snap_stb) begin
      tx_p0 <= lamp_word(ema, addr, data, run);
    end else if (shift_stb) begin
      tx_p0 <= {tx_p0[CHAIN_BITS-2:0], 1'b0};
    end
  end

  // ---- p1: switch deserializer ----
  always_ff @(posedge clk) begin
    if (sample_stb) begin
      rx_p1 <= {sdi, rx_p1[CHAIN_BITS-1:1]};
    end
  end

`ifdef PANEL_DEBOUNCE_EN
  // ---- p2: previous-frame switch history ----
  always_ff @(posedge clk) begin
    if (hist_stb) begin
      hist_p2 <= rx_p1[SW_BITS-1:0];
    end
  end
`endif

  // Frame sequencer with registered pin and switch outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_LOAD;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      latch      <= 1'b0;
      load_n     <= 1'b1;
      sdo        <= 1'b1;
      frame_done <= 1'b0;
      sr         <= '0;
      dsel       <= '0;
      ctl        <= '0;
`ifdef PANEL_DEBOUNCE_EN
      primed     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          load_n <= 1'b0;
          sclk   <= 1'b0;
          latch  <= 1'b0;
          if (div_cnt == PHASE_LAST) begin
            // First lamp bit goes out as LOAD ends; sclk is still low.
            div_cnt <= '0;
            bit_cnt <= '0;
            load_n  <= 1'b1;
            sdo     <= ~tx_p0[CHAIN_BITS-1];
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        ST_SHIFT: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                latch <= 1'b1;
                state <= ST_LATCH;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                sdo     <= ~tx_p0[CHAIN_BITS-1];
              end
            end
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        ST_LATCH: begin
          sclk <= 1'b0;
          if (div_cnt == PHASE_LAST) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            latch      <= 1'b0;
            load_n     <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_LOAD;
`ifdef PANEL_DEBOUNCE_EN
            // Only accept a switch image seen on two consecutive frames.
            if (primed && (rx_p1[SW_BITS-1:0] == hist_p2)) begin
              sr   <= sr_decode(rx_p1[SW_BITS-1:0]);
              dsel <= dsel_decode(rx_p1[SW_BITS-1:0]);
              ctl  <= ctl_decode(rx_p1[SW_BITS-1:0]);
            end
            primed <= 1'b1;
`else
            sr   <= sr_decode(rx_p1[SW_BITS-1:0]);
            dsel <= dsel_decode(rx_p1[SW_BITS-1:0]);
            ctl  <= ctl_decode(rx_p1[SW_BITS-1:0]);
`endif
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panel_scanner.sv
// -----------------------------------------------------------------------------
// tb_panel_scanner
//
// Scoreboard bench for panel_scanner (CLK_DIV=2, 136-clk frames). The
// stimulus process sets lamp inputs and switch-pin values for a frame and
// pushes the expected sdo word and switch outputs into a queue. A monitor
// process rebuilds the sdo word from sclk rises, measures frame length and
// latch timing, and pops/compares at each frame_done. A 74HC165 model feeds
// sdi from the switch-pin values.
// -----------------------------------------------------------------------------
module tb_panel_scanner;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_CLKS = 68 * CLK_DIV;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  ema = '0;
  logic [11:0] addr = '0;
  logic [11:0] data = '0;
  logic        run = 1'b0;
  logic        sclk, sdo, latch, load_n, sdi, frame_done;
  logic [11:0] sr;
  logic [5:0]  dsel;
  logic [8:0]  ctl;

  panel_scanner #(.CLK_DIV(CLK_DIV), .CHAIN_BITS(32)) dut (
    .clk(clk), .resetn(resetn), .ema(ema), .addr(addr), .data(data),
    .run(run), .sclk(sclk), .sdo(sdo), .latch(latch), .load_n(load_n),
    .sdi(sdi), .sr(sr), .dsel(dsel), .ctl(ctl), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  // Lamp inputs, switch pin levels (active-low), expected sdo word (first
  // bit in bit 31) and expected true-polarity switch outputs.
  typedef struct packed {
    logic [2:0]  ema;
    logic [11:0] addr;
    logic [11:0] data;
    logic        run;
    logic [11:0] srp;
    logic [5:0]  dp;
    logic [8:0]  cp;
    logic [31:0] sdo_x;
    logic [11:0] sr_x;
    logic [5:0]  ds_x;
    logic [8:0]  ct_x;
  } vec_t;

  localparam vec_t VA = '{3'o5, 12'o7402, 12'o0017, 1'b1,
                          12'o0000, 6'o77, 9'b111111110,
                          32'h41FBFE0F, 12'o7777, 6'o00, 9'b000000001};
  localparam vec_t VB = '{3'o2, 12'o1234, 12'o4321, 1'b0,
                          12'o5252, 6'o12, 9'h0F0,
                          32'hBAC6E5DF, 12'o2525, 6'o65, 9'h10F};
  localparam vec_t VC = '{3'o0, 12'o0000, 12'o0000, 1'b0,
                          12'o0000, 6'o77, 9'b111111110,
                          32'hFFFFFFFF, 12'o7777, 6'o00, 9'b000000001};
  localparam vec_t VD = '{3'o7, 12'o7777, 12'o7777, 1'b1,
                          12'o5252, 6'o12, 9'h0F0,
                          32'h0000000F, 12'o2525, 6'o65, 9'h10F};
  localparam vec_t VE = '{3'o7, 12'o0000, 12'o7777, 1'b1,
                          12'o5252, 6'o12, 9'h0F0,
                          32'h1FFE000F, 12'o2525, 6'o65, 9'h10F};
  // Same lamps as VA, halt pin released (ctl pin bit 5 low -> halt on).
  localparam vec_t VH = '{3'o5, 12'o7402, 12'o0017, 1'b1,
                          12'o0000, 6'o77, 9'b111011110,
                          32'h41FBFE0F, 12'o7777, 6'o00, 9'b000100001};

  // ---------------- switch chain model (74HC165) ----------------
  logic [11:0] sr_pin = '0;
  logic [5:0]  dsel_pin = '0;
  logic [8:0]  ctl_pin = '0;
  logic [31:0] chain_sh = '1;
  logic        chain_sclk_q = 1'b0;

  function automatic logic [31:0] pin_word(input logic [11:0] s,
                                           input logic [5:0] d,
                                           input logic [8:0] c);
    logic [31:0] w;
    w = '1;
    for (int i = 0; i < 12; i++) w[31-i] = s[i];
    for (int i = 0; i < 6; i++)  w[19-i] = d[i];
    for (int i = 0; i < 9; i++)  w[13-i] = c[i];
    return w;
  endfunction

  assign sdi = chain_sh[31];

  always @(posedge clk) begin
    #1;
    if (!load_n)
      chain_sh = pin_word(sr_pin, dsel_pin, ctl_pin);
    else if (sclk && !chain_sclk_q)
      chain_sh = {chain_sh[30:0], 1'b1};
    chain_sclk_q = sclk;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] sdo_w;
    logic [11:0] sr;
    logic [5:0]  ds;
    logic [8:0]  ct;
  } exp_t;

  exp_t exp_q[$];

  // Expected switch-output state (follows the debounce rule when enabled).
  logic [11:0] m_sr = '0;
  logic [5:0]  m_ds = '0;
  logic [8:0]  m_ct = '0;
  logic [26:0] m_prev = '0;
  bit          m_primed = 1'b0;

  task automatic model_reset();
    m_sr = '0; m_ds = '0; m_ct = '0; m_primed = 1'b0;
  endtask

  task automatic drive_push(input vec_t v);
    ema = v.ema; addr = v.addr; data = v.data; run = v.run;
    sr_pin = v.srp; dsel_pin = v.dp; ctl_pin = v.cp;
`ifdef PANEL_DEBOUNCE_EN
    if (m_primed && ({v.cp, v.dp, v.srp} == m_prev)) begin
      m_sr = v.sr_x; m_ds = v.ds_x; m_ct = v.ct_x;
    end
    m_prev = {v.cp, v.dp, v.srp};
    m_primed = 1'b1;
`else
    m_sr = v.sr_x; m_ds = v.ds_x; m_ct = v.ct_x;
`endif
    exp_q.push_back('{v.sdo_x, m_sr, m_ds, m_ct});
  endtask

  // ---------------- monitor ----------------
  int          clk_cnt = 0;
  int          cap_cnt = 0;
  logic [31:0] cap = '0;
  logic        mon_sclk_q = 1'b0;
  logic        mon_latch_q = 1'b0;
  bit          mon_rst;
  exp_t        mon_e;

  always @(posedge clk) begin
    mon_rst = !resetn;
    #1;
    if (mon_rst) begin
      clk_cnt = 0;
      cap_cnt = 0;
    end else begin
      clk_cnt++;
      if (sclk && !mon_sclk_q) begin
        cap = {cap[30:0], sdo};
        cap_cnt++;
      end
      if (latch && !mon_latch_q)
        check("latch_after_32_bits", cap_cnt, 32);
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_done: got a frame, expected none");
        end else begin
          mon_e = exp_q.pop_front();
          check("sdo_word", cap, mon_e.sdo_w);
          check("sdo_bit_count", cap_cnt, 32);
          check("frame_length", clk_cnt, FRAME_CLKS);
          check("sr", {20'd0, sr}, {20'd0, mon_e.sr});
          check("dsel", {26'd0, dsel}, {26'd0, mon_e.ds});
          check("ctl", {23'd0, ctl}, {23'd0, mon_e.ct});
        end
        clk_cnt = 0;
        cap_cnt = 0;
      end
    end
    mon_sclk_q = sclk;
    mon_latch_q = latch;
  end

  // ---------------- stimulus ----------------
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2 * FRAME_CLKS + 20);
    if (!frame_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: no frame_done after %0d clks, expected %0d", n, FRAME_CLKS);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
    check({tag, "_latch"}, {31'd0, latch}, 32'd0);
    check({tag, "_load_n"}, {31'd0, load_n}, 32'd1);
    check({tag, "_sdo"}, {31'd0, sdo}, 32'd1);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_sr"}, {20'd0, sr}, 32'd0);
    check({tag, "_dsel"}, {26'd0, dsel}, 32'd0);
    check({tag, "_ctl"}, {23'd0, ctl}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    model_reset();
    drive_push(VA);
    resetn = 1'b1;

    wait_frame(); drive_push(VB);
    wait_frame(); drive_push(VC);
    wait_frame(); drive_push(VD);
    // Lamp change in the middle of SHIFT must not reach this frame.
    repeat (40) @(negedge clk);
    addr = 12'o0000;
    wait_frame(); drive_push(VE);
    wait_frame();

    // Abort the following frame around bit 17 with a one-clk reset.
    repeat (72) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    model_reset();
    drive_push(VB);
    resetn = 1'b1;

    // Halt pin toggling every frame, then held for two frames.
    wait_frame(); drive_push(VA);
    wait_frame(); drive_push(VH);
    wait_frame(); drive_push(VA);
    wait_frame(); drive_push(VH);
    wait_frame(); drive_push(VH);
    wait_frame();

    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
